hs_protocol_checker: RTL and testbench

Parametrised, synthesisable valid/ready handshake checker for `NUM_CH` independent channels. It is the clocked, multi-channel successor to the single-property checkers used in our verification IP. Each channel runs its own state machine that flags three protocol violations:

- valid dropped before acceptance
- payload changed while stalled
- stall longer than `TIMEOUT` cycles

It reports each violation as a registered pulse, a sticky flag and a saturating counter. It sits passively beside any valid/ready interface, in simulation or in silicon debug.

---
 rtl/hs_chk_pkg.sv | 17 +
 rtl/hs_chk_channel.sv | 138 +++++++++++++
 rtl/hs_protocol_checker.sv | 50 +++++
 tb/tb_hs_protocol_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_chk_pkg.sv
// Shared types and constants for the valid/ready handshake checker.
package hs_chk_pkg;

  // Per-channel protocol tracking states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PENDING   = 2'd1,
    TIMED_OUT = 2'd2
  } hs_state_e;

  // Bit positions inside a channel's error-pulse vector
  localparam int ERR_DROP = 0;
  localparam int ERR_DATA = 1;
  localparam int ERR_TO   = 2;
  localparam int ERR_W    = 3;

endpackage : hs_chk_pkg

// File: rtl/hs_chk_channel.sv
// One monitored valid/ready channel: protocol FSM, stall counter, payload
// capture, registered error pulses, sticky flag and saturating error count.
module hs_chk_channel
  import hs_chk_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic              err_drop,
  output logic              err_data,
  output logic              err_timeout,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int                   STALL_W   = $clog2(TIMEOUT + 32'd1);
  localparam logic [STALL_W-1:0]   STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_W-1:0]   STALL_LIM = STALL_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};

  hs_state_e          state_r, state_nxt_s;
  logic [STALL_W-1:0] stall_r, stall_nxt_s, stall_inc_s;
  logic [DATA_W-1:0]  cap_r, cap_nxt_s;
  logic [ERR_W-1:0]   err_r, err_nxt_s;
  logic               sticky_r, sticky_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;

  // Next-state decode: which error (if any) this sample raises and where the FSM goes
  always_comb begin
    state_nxt_s = state_r;
    stall_nxt_s = stall_r;
    cap_nxt_s   = cap_r;
    err_nxt_s   = {ERR_W{1'b0}};
    stall_inc_s = stall_r + 1'b1;
    if (!enable) begin
      state_nxt_s = IDLE;
      stall_nxt_s = {STALL_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (valid && !ready) begin
            state_nxt_s = PENDING;
            stall_nxt_s = STALL_ONE;
            cap_nxt_s   = data;
          end else begin
            stall_nxt_s = {STALL_W{1'b0}};
          end
        end
        PENDING: begin
          if (!valid) begin
            err_nxt_s[ERR_DROP] = 1'b1;
            state_nxt_s         = IDLE;
            stall_nxt_s         = {STALL_W{1'b0}};
          end else if (ready) begin
            state_nxt_s = IDLE;
            stall_nxt_s = {STALL_W{1'b0}};
          end else begin
            err_nxt_s[ERR_DATA] = (data != cap_r);
            cap_nxt_s           = data;
            stall_nxt_s         = stall_inc_s;
            if (stall_inc_s == STALL_LIM) begin
              err_nxt_s[ERR_TO] = 1'b1;
              state_nxt_s       = TIMED_OUT;
            end else begin
              err_nxt_s[ERR_TO] = 1'b0;
            end
          end
        end
        TIMED_OUT: begin
          // Already reported; wait quietly for the transaction to end either way
          if (!valid || ready) begin
            state_nxt_s = IDLE;
            stall_nxt_s = {STALL_W{1'b0}};
          end else begin
            state_nxt_s = TIMED_OUT;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          stall_nxt_s = {STALL_W{1'b0}};
        end
      endcase
    end
  end

  // Sticky flag and saturating counter; clear beats a same-cycle error
  always_comb begin
    sticky_nxt_s = sticky_r;
    cnt_nxt_s    = cnt_r;
    if (clear) begin
      sticky_nxt_s = 1'b0;
      cnt_nxt_s    = {CNT_W{1'b0}};
    end else if (|err_nxt_s) begin
      sticky_nxt_s = 1'b1;
      if (cnt_r != CNT_MAX) begin
        cnt_nxt_s = cnt_r + 1'b1;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      sticky_nxt_s = sticky_r;
    end
  end

  // Single state register for FSM, stall counter, capture and all outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      stall_r  <= {STALL_W{1'b0}};
      cap_r    <= {DATA_W{1'b0}};
      err_r    <= {ERR_W{1'b0}};
      sticky_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      stall_r  <= stall_nxt_s;
      cap_r    <= cap_nxt_s;
      err_r    <= err_nxt_s;
      sticky_r <= sticky_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  assign err_drop    = err_r[ERR_DROP];
  assign err_data    = err_r[ERR_DATA];
  assign err_timeout = err_r[ERR_TO];
  assign err_sticky  = sticky_r;
  assign err_cnt     = cnt_r;

endmodule : hs_chk_channel

// File: rtl/hs_protocol_checker.sv
// Passive multi-channel valid/ready protocol checker: one independent
// checker per channel plus a global any-error summary.
module hs_protocol_checker
  import hs_chk_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        err_drop,
  output logic [NUM_CH-1:0]        err_data,
  output logic [NUM_CH-1:0]        err_timeout,
  output logic [NUM_CH-1:0]        err_sticky,
  output logic [NUM_CH*CNT_W-1:0]  err_cnt,
  output logic                     any_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hs_chk_channel #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .clear       (clear),
      .valid       (valid[i]),
      .ready       (ready[i]),
      .data        (data[i*DATA_W +: DATA_W]),
      .err_drop    (err_drop[i]),
      .err_data    (err_data[i]),
      .err_timeout (err_timeout[i]),
      .err_sticky  (err_sticky[i]),
      .err_cnt     (err_cnt[i*CNT_W +: CNT_W])
    );
  end : g_ch

  // Summary flag straight from the sticky registers, no added latency
  assign any_err = |err_sticky;

endmodule : hs_protocol_checker

// File: tb/tb_hs_protocol_checker.sv
// Self-checking bench: directed scenarios then randomized traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_hs_protocol_checker;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     enable;
  logic                     clear;
  logic [NUM_CH-1:0]        valid;
  logic [NUM_CH-1:0]        ready;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH-1:0]        err_drop, err_data, err_timeout, err_sticky;
  logic [NUM_CH*CNT_W-1:0]  err_cnt;
  logic                     any_err;

  hs_protocol_checker #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .valid(valid), .ready(ready), .data(data),
    .err_drop(err_drop), .err_data(err_data), .err_timeout(err_timeout),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .any_err(any_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: one transaction record per channel
  bit in_txn   [NUM_CH];
  bit reported [NUM_CH];
  int stalls   [NUM_CH];
  int held_val [NUM_CH];
  bit m_drop   [NUM_CH];
  bit m_data   [NUM_CH];
  bit m_to     [NUM_CH];
  bit m_sticky [NUM_CH];
  int m_cnt    [NUM_CH];

  int n_data2, n_to2;
  int cur_data [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      in_txn[i] = 1'b0; reported[i] = 1'b0; stalls[i] = 0; held_val[i] = 0;
      m_drop[i] = 1'b0; m_data[i] = 1'b0; m_to[i] = 1'b0;
      m_sticky[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  // Applies the protocol rules to the inputs sampled at this edge
  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      bit v, r;
      int d;
      v = valid[i]; r = ready[i]; d = int'(data[i*DATA_W +: DATA_W]);
      m_drop[i] = 1'b0; m_data[i] = 1'b0; m_to[i] = 1'b0;
      if (!enable) begin
        in_txn[i] = 1'b0; reported[i] = 1'b0; stalls[i] = 0;
      end else if (!in_txn[i]) begin
        if (v && !r) begin
          in_txn[i] = 1'b1; stalls[i] = 1; held_val[i] = d;
        end
      end else if (reported[i]) begin
        if (!v || r) begin
          in_txn[i] = 1'b0; reported[i] = 1'b0; stalls[i] = 0;
        end
      end else if (!v) begin
        m_drop[i] = 1'b1; in_txn[i] = 1'b0; stalls[i] = 0;
      end else if (r) begin
        in_txn[i] = 1'b0; stalls[i] = 0;
      end else begin
        m_data[i] = (d != held_val[i]);
        held_val[i] = d;
        stalls[i] = stalls[i] + 1;
        if (stalls[i] == TIMEOUT) begin
          m_to[i] = 1'b1; reported[i] = 1'b1;
        end
      end
      if (clear) begin
        m_sticky[i] = 1'b0; m_cnt[i] = 0;
      end else if (m_drop[i] || m_data[i] || m_to[i]) begin
        m_sticky[i] = 1'b1;
        if (m_cnt[i] < CNT_SAT) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic check_all();
    bit any_exp;
    any_exp = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("ch%0d_drop", i), 32'(err_drop[i]), 32'(m_drop[i]));
      check($sformatf("ch%0d_data", i), 32'(err_data[i]), 32'(m_data[i]));
      check($sformatf("ch%0d_timeout", i), 32'(err_timeout[i]), 32'(m_to[i]));
      check($sformatf("ch%0d_sticky", i), 32'(err_sticky[i]), 32'(m_sticky[i]));
      check($sformatf("ch%0d_cnt", i), 32'(err_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
      any_exp = any_exp | m_sticky[i];
    end
    check("any_err", 32'(any_err), 32'(any_exp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (err_data[2]) n_data2++;
    if (err_timeout[2]) n_to2++;
    check_all();
  endtask

  task automatic set_ch(input int i, input bit v, input bit r, input logic [DATA_W-1:0] d);
    valid[i] = v;
    ready[i] = r;
    data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle_all();
    valid = '0; ready = '0; data = '0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
    idle_all();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    check_all();
    rst_n = 1'b1;

    // Clean traffic on ch0: 3 stalled cycles then accepted, constant payload
    for (int k = 0; k < 3; k++) begin set_ch(0, 1'b1, 1'b0, 8'hA5); tick(); end
    set_ch(0, 1'b1, 1'b1, 8'hA5); tick();
    set_ch(0, 1'b0, 1'b0, 8'h00); tick();
    check("clean_cnt0", 32'(err_cnt[0 +: CNT_W]), 32'd0);

    // Drop on ch1 after 2 stalled cycles
    for (int k = 0; k < 2; k++) begin set_ch(1, 1'b1, 1'b0, 8'h3C); tick(); end
    set_ch(1, 1'b0, 1'b0, 8'h3C); tick();
    check("drop_pulse1", 32'(err_drop[1]), 32'd1);
    check("drop_sticky1", 32'(err_sticky[1]), 32'd1);
    check("drop_cnt1", 32'(err_cnt[1*CNT_W +: CNT_W]), 32'd1);
    check("drop_any", 32'(any_err), 32'd1);
    tick();
    check("drop_once1", 32'(err_drop[1]), 32'd0);

    // Payload change at stall cycle 5, then held through timeout on ch2
    n_data2 = 0; n_to2 = 0;
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      set_ch(2, 1'b1, 1'b0, (k < 5) ? 8'h11 : 8'h22); tick();
    end
    set_ch(2, 1'b1, 1'b1, 8'h22); tick();
    set_ch(2, 1'b0, 1'b0, 8'h00); tick();
    check("dto_ndata2", 32'(n_data2), 32'd1);
    check("dto_nto2", 32'(n_to2), 32'd1);
    check("dto_cnt2", 32'(err_cnt[2*CNT_W +: CNT_W]), 32'd2);

    // Five drops on ch3 saturate the 2-bit counter
    for (int e = 0; e < 5; e++) begin
      set_ch(3, 1'b1, 1'b0, 8'h55); tick();
      set_ch(3, 1'b0, 1'b0, 8'h55); tick();
    end
    check("sat_cnt3", 32'(err_cnt[3*CNT_W +: CNT_W]), 32'd3);
    set_ch(3, 1'b1, 1'b0, 8'h55); tick();
    set_ch(3, 1'b0, 1'b0, 8'h55); clear = 1'b1; tick();
    clear = 1'b0;
    check("clr_pulse3", 32'(err_drop[3]), 32'd1);
    check("clr_cnt3", 32'(err_cnt[3*CNT_W +: CNT_W]), 32'd0);
    check("clr_sticky3", 32'(err_sticky[3]), 32'd0);

    // Enable dropped mid-stall: no error when valid later falls
    for (int k = 0; k < 3; k++) begin set_ch(0, 1'b1, 1'b0, 8'h77); tick(); end
    enable = 1'b0; tick();
    check("en_nopulse", 32'({err_drop, err_data, err_timeout}), 32'd0);
    enable = 1'b1; set_ch(0, 1'b0, 1'b0, 8'h00); tick();
    check("en_idle_drop0", 32'(err_drop[0]), 32'd0);

    // Asynchronous reset mid-stall
    for (int k = 0; k < 3; k++) begin set_ch(0, 1'b1, 1'b0, 8'h99); tick(); end
    #2 rst_n = 1'b0;
    #1;
    check("arst_pulses", 32'({err_drop, err_data, err_timeout}), 32'd0);
    check("arst_sticky", 32'(err_sticky), 32'd0);
    check("arst_cnt", 32'(err_cnt), 32'd0);
    check("arst_any", 32'(any_err), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    set_ch(0, 1'b0, 1'b0, 8'h00); tick();
    check("arst_nodrop0", 32'(err_drop[0]), 32'd0);

    // All channels drop in the same cycle
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 1'b0, 8'(i));
    tick();
    idle_all(); tick();
    check("conc_drops", 32'(err_drop), 32'hF);
    check("conc_any", 32'(any_err), 32'd1);

    // Randomized traffic in phases of differing stall pressure
    for (int i = 0; i < NUM_CH; i++) cur_data[i] = 0;
    for (int ph = 0; ph < 12; ph++) begin
      int rdy_div;
      rdy_div = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 6 : 24);
      for (int c = 0; c < 250; c++) begin
        enable = ($urandom_range(0, 79) != 0);
        clear  = ($urandom_range(0, 99) == 0);
        for (int i = 0; i < NUM_CH; i++) begin
          if ($urandom_range(0, 7) == 0) cur_data[i] = int'($urandom_range(0, 255));
          set_ch(i, ($urandom_range(0, 19) != 0), ($urandom_range(0, rdy_div - 1) == 0),
                 8'(cur_data[i]));
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_hs_protocol_checker
